instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer end of the program-counter interface: takes each PC value the clock/PC counter
//  publishes, issues one instruction-memory read via a req/gnt/rvalid handshake, and holds the
//  fetched word with valid/ready for the decode stage. Sits between the PC counter and decode
//  in the multicycle CPU datapath.
// PARAMETERS
//  PC_W       8             width of incoming program counter (byte address)
//  DATA_W     32            instruction / memory data width
//  NOP_INSTR  32'h00000013  word presented on error/abort
//  TIMEOUT    16            max cycles in WAIT before abort (FETCH_TIMEOUT_EN only)
// PORTS
//  clock        in   1         rising-edge clock
//  reset        in   1         asynchronous, active-low reset
//  pc           in   PC_W      program counter byte address
//  pc_strobe    in   1         new PC present; accepted when pc_ready=1
//  pc_ready     out  1         high only in IDLE (combinational from state)
//  mem_req      out  1         read request, held until mem_gnt
//  mem_addr     out  PC_W-2    word address = captured pc[PC_W-1:2]
//  mem_gnt      in   1         request accepted
//  mem_rvalid   in   1         read data valid
//  mem_rdata    in   DATA_W    read data
//  instr        out  DATA_W    fetched instruction, stable while instr_valid
//  instr_valid  out  1         instruction available
//  instr_ready  in   1         decode accepts instruction
//  instr_err    out  1         qualifies instr_valid: misaligned PC or timeout
//  fetch_count  out  16        completed handoffs (valid&ready), wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; mem_req, mem_addr, instr, instr_valid, instr_err,
//   fetch_count all 0. Reset mid-fetch abandons request; any later rvalid ignored in IDLE.
//  FSM IDLE->REQ->WAIT->HOLD->IDLE, all outputs registered except pc_ready.
//  IDLE: on pc_strobe, capture pc. If pc[1:0]!=0 -> HOLD, instr=NOP_INSTR, instr_err=1, no
//   memory access. Else -> REQ, mem_req=1, mem_addr=pc[PC_W-1:2].
//  REQ: hold mem_req/mem_addr stable until mem_gnt; on gnt drop mem_req -> WAIT.
//  WAIT: mem_rvalid sampled only here (rvalid coincident with gnt in REQ is ignored);
//   on rvalid capture mem_rdata into instr, instr_err=0 -> HOLD.
//  HOLD: instr_valid=1, instr/instr_err stable; on instr_ready -> IDLE, instr_valid=0,
//   fetch_count+1. pc_strobe outside IDLE is ignored (pc_ready=0); producer must retry.
//  Min latency: strobe edge 0 -> mem_req edge 1 -> (gnt same cycle) WAIT edge 2 ->
//   (rvalid) instr_valid edge 3. Back-to-back: next strobe accepted cycle after handoff.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined: counter cleared on entering WAIT, increments each WAIT cycle;
//   reaching TIMEOUT without rvalid -> HOLD with instr=NOP_INSTR, instr_err=1. rvalid on the
//   terminal cycle wins over timeout.
//  Undefined: no counter; WAIT waits indefinitely; instr_err only from misalignment.
// STRUCTURE
//  Shared package cpu_fetch_pkg: fetch_state_t enum {IDLE,REQ,WAIT,HOLD}, NOP_INSTR constant,
//   FETCH_CNT_W=16. Sub-module fetch_timeout_ctr (load/enable/expired) instantiated only
//   under FETCH_TIMEOUT_EN; remainder is a single FSM + capture registers.
// TESTING
//  1 reset=0 mid-WAIT -> next edge-independent: instr_valid=0, mem_req=0, fetch_count=0; late
//    rvalid after release does not produce instr_valid.
//  2 pc=8'h04 strobe, gnt immediately, rdata=32'hDEADBEEF next cycle -> mem_addr=6'h01,
//    instr=32'hDEADBEEF, instr_valid at edge 3, instr_err=0; ready -> fetch_count=1.
//  3 pc=8'h06 strobe -> no mem_req ever, instr=32'h00000013, instr_err=1, instr_valid=1.
//  4 gnt delayed 4 cycles, instr_ready held low 3 cycles -> mem_addr/instr stable throughout,
//    pc_strobe pulses during HOLD ignored (pc_ready=0), single count increment.
//  5 FETCH_TIMEOUT_EN, no rvalid -> after 16 WAIT cycles instr=NOP, instr_err=1; without
//    macro same stimulus stays in WAIT for 100 cycles.
//  6 preload 65535 handoffs (or force counter) -> next handoff wraps fetch_count to 0.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and constants for the multicycle CPU datapath.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned FETCH_CNT_W = 16;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// PC-in / memory / decode-out signal bundle of the instruction fetch unit.
// master: fetch unit side; slave: PC producer, memory and decode side.
interface instr_fetch_unit_if
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 32
) ();

  logic [PC_W-1:0]        pc;
  logic                   pc_strobe;
  logic                   pc_ready;
  logic                   mem_req;
  logic [PC_W-3:0]        mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic [DATA_W-1:0]      mem_rdata;
  logic [DATA_W-1:0]      instr;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   instr_err;
  logic [FETCH_CNT_W-1:0] fetch_count;

  modport master (
    input  pc, pc_strobe, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, instr, instr_valid, instr_err, fetch_count
  );

  modport slave (
    output pc, pc_strobe, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr, instr_valid, instr_err, fetch_count
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// WAIT-state cycle counter; expired_o flags the last permitted WAIT cycle.
module fetch_timeout_ctr #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Timeout + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counts completed WAIT cycles, so Timeout-1 means this is the Timeout-th one.
  assign expired_o = enable_i && (cnt_q == CntW'(Timeout - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts a PC, performs one req/gnt/rvalid memory read and holds
// the word for decode. Optional WAIT timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(cpu_fetch_pkg::NOP_INSTR)
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 16
`endif
) (
  input logic               clock,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t           state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic [PC_W-3:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   instr_err_q, instr_err_d;
  logic [FETCH_CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic                   wait_expired;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .Timeout (TIMEOUT)
  ) u_timeout (
    .clk_i     (clock),
    .rst_ni    (reset),
    .load_i    (state_q == REQ && bus.mem_gnt),
    .enable_i  (state_q == WAIT),
    .expired_o (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instr_err_d   = instr_err_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.pc_strobe) begin
          if (pc_misaligned(bus.pc[1:0])) begin
            state_d       = HOLD;
            instr_d       = NOP_INSTR;
            instr_err_d   = 1'b1;
            instr_valid_d = 1'b1;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = bus.pc[PC_W-1:2];
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
      end
      WAIT: begin
        // Data beats the timeout when both land on the same cycle.
        if (bus.mem_rvalid) begin
          state_d       = HOLD;
          instr_d       = bus.mem_rdata;
          instr_err_d   = 1'b0;
          instr_valid_d = 1'b1;
        end else if (wait_expired) begin
          state_d       = HOLD;
          instr_d       = NOP_INSTR;
          instr_err_d   = 1'b1;
          instr_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          state_d       = IDLE;
          instr_valid_d = 1'b0;
          fetch_count_d = fetch_count_q + FETCH_CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_err_q   <= instr_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc_ready    = (state_q == IDLE);
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_err   = instr_err_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model checked every cycle plus directed
// literal checks. Timeout scenario adapts to FETCH_TIMEOUT_EN.
module tb_instr_fetch_unit;
  import cpu_fetch_pkg::*;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic preload = 1'b0;

  instr_fetch_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_unit #(
    .PC_W      (PC_W),
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: tracks which transaction phase is outstanding, not the RTL state encoding.
  logic        m_req, m_wait, m_valid, m_err;
  logic [5:0]  m_addr;
  logic [31:0] m_instr;
  logic [15:0] m_cnt;
  int          m_waited;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_req <= 0; m_wait <= 0; m_valid <= 0; m_err <= 0;
      m_addr <= 0; m_instr <= 0; m_cnt <= 0; m_waited <= 0;
    end else begin
      if (m_valid) begin
        if (bus.instr_ready) begin
          m_valid <= 0;
          m_cnt   <= m_cnt + 16'd1;
        end
      end else if (m_wait) begin
        if (bus.mem_rvalid) begin
          m_wait <= 0; m_valid <= 1; m_instr <= bus.mem_rdata; m_err <= 0;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (m_waited + 1 == TIMEOUT) begin
          m_wait <= 0; m_valid <= 1; m_instr <= NOP; m_err <= 1;
        end else begin
          m_waited <= m_waited + 1;
        end
`endif
      end else if (m_req) begin
        if (bus.mem_gnt) begin
          m_req <= 0; m_wait <= 1; m_waited <= 0;
        end
      end else if (bus.pc_strobe) begin
        if (bus.pc[1:0] != 2'b00) begin
          m_valid <= 1; m_instr <= NOP; m_err <= 1;
        end else begin
          m_req <= 1; m_addr <= bus.pc[7:2];
        end
      end
      if (preload) m_cnt <= 16'hFFFF;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #2;
      chk("pc_ready", {31'd0, bus.pc_ready}, {31'd0, !(m_req || m_wait || m_valid)});
      chk("mem_req", {31'd0, bus.mem_req}, {31'd0, m_req});
      chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
      chk("fetch_count", {16'd0, bus.fetch_count}, {16'd0, m_cnt});
      if (m_req) chk("mem_addr", {26'd0, bus.mem_addr}, {26'd0, m_addr});
      if (m_valid) begin
        chk("instr", bus.instr, m_instr);
        chk("instr_err", {31'd0, bus.instr_err}, {31'd0, m_err});
      end
    end
  end

  task automatic strobe_pc(input logic [7:0] p);
    bus.pc = p;
    bus.pc_strobe = 1'b1;
    @(negedge clock);
    bus.pc_strobe = 1'b0;
  endtask

  task automatic handoff();
    bus.instr_ready = 1'b1;
    @(negedge clock);
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pc = '0; bus.pc_strobe = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
    bus.mem_rdata = '0; bus.instr_ready = 0;
    repeat (2) @(negedge clock);
    chk("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst mem_addr", {26'd0, bus.mem_addr}, 32'd0);
    chk("rst instr", bus.instr, 32'd0);
    chk("rst instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst instr_err", {31'd0, bus.instr_err}, 32'd0);
    chk("rst fetch_count", {16'd0, bus.fetch_count}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Aligned fetch at minimum latency.
    strobe_pc(8'h04);
    chk("t2 mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t2 mem_addr", {26'd0, bus.mem_addr}, 32'h01);
    bus.mem_gnt = 1'b1;
    @(negedge clock);
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    chk("t2 valid early", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clock);
    bus.mem_rvalid = 1'b0;
    chk("t2 valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t2 instr", bus.instr, 32'hDEADBEEF);
    chk("t2 err", {31'd0, bus.instr_err}, 32'd0);
    handoff();
    chk("t2 count", {16'd0, bus.fetch_count}, 32'd1);

    // Asynchronous reset while waiting for read data.
    strobe_pc(8'h10);
    bus.mem_gnt = 1'b1;
    @(negedge clock);
    bus.mem_gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t1 valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("t1 mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("t1 count", {16'd0, bus.fetch_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    repeat (2) @(negedge clock);
    bus.mem_rvalid = 1'b0;
    chk("t1 late rvalid", {31'd0, bus.instr_valid}, 32'd0);

    // Misaligned PC: NOP with error, no memory access.
    strobe_pc(8'h06);
    chk("t3 mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("t3 valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t3 instr", bus.instr, 32'h00000013);
    chk("t3 err", {31'd0, bus.instr_err}, 32'd1);
    handoff();
    chk("t3 count", {16'd0, bus.fetch_count}, 32'd1);

    // Slow grant, slow decode, strobes during HOLD ignored.
    strobe_pc(8'h20);
    repeat (4) @(negedge clock);
    chk("t4 addr held", {26'd0, bus.mem_addr}, 32'h08);
    bus.mem_gnt = 1'b1;
    @(negedge clock);
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h12345678;
    @(negedge clock);
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pc = 8'h40;
      bus.pc_strobe = (i != 1);
      @(negedge clock);
    end
    bus.pc_strobe = 1'b0;
    chk("t4 instr held", bus.instr, 32'h12345678);
    handoff();
    chk("t4 count", {16'd0, bus.fetch_count}, 32'd2);
    chk("t4 no new req", {31'd0, bus.mem_req}, 32'd0);

    // Read data never arrives.
    strobe_pc(8'h30);
    bus.mem_gnt = 1'b1;
    @(negedge clock);
    bus.mem_gnt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (TIMEOUT - 1) @(negedge clock);
    chk("t5 not yet", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clock);
    chk("t5 valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t5 instr", bus.instr, NOP);
    chk("t5 err", {31'd0, bus.instr_err}, 32'd1);
`else
    repeat (100) @(negedge clock);
    chk("t5 still waiting", {31'd0, bus.instr_valid}, 32'd0);
    chk("t5 pc_ready", {31'd0, bus.pc_ready}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    @(negedge clock);
    bus.mem_rvalid = 1'b0;
    chk("t5 instr", bus.instr, 32'hA5A5A5A5);
    chk("t5 err", {31'd0, bus.instr_err}, 32'd0);
`endif
    handoff();
    chk("t5 count", {16'd0, bus.fetch_count}, 32'd3);

    // Counter wrap after preloading the last value before rollover.
    force dut.fetch_count_q = 16'hFFFF;
    preload = 1'b1;
    #1 release dut.fetch_count_q;
    @(negedge clock);
    preload = 1'b0;
    chk("t6 preload", {16'd0, bus.fetch_count}, 32'h0000FFFF);
    strobe_pc(8'hFC);
    chk("t6 mem_addr", {26'd0, bus.mem_addr}, 32'h3F);
    bus.mem_gnt = 1'b1;
    @(negedge clock);
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0badf00d;
    @(negedge clock);
    bus.mem_rvalid = 1'b0;
    handoff();
    chk("t6 wrap", {16'd0, bus.fetch_count}, 32'd0);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
